serial_frame_rx: RTL
====================

Name: serial_frame_rx

Overview:
- Receive side of the team's single-wire, strobe-qualified serial frame link. The matching transmitter serializes each word as: start bit, data bits LSB first, parity bit.
- This block deserializes frames, checks parity, and presents each word on a one-entry valid/ready output register.
- It is the sequential test vehicle for resizer buffering and repair flows. SIN and SVALID arrive over long, high-fanout nets that the flows buffer.

Parameters:
DATA_W, 8, number of data bits per frame (2..32)
EVEN_PAR, 1, 1 = even parity (parity bit = XOR of data bits); 0 = odd parity (parity bit = XNOR of data bits)

Ports:
CK  input  1  clock; all logic on the rising edge
RST  input  1  synchronous reset, active-high
SIN  input  1  serial data; sampled only when SVALID=1
SVALID  input  1  bit strobe; one serial bit per cycle in which it is high
DOUT  output  DATA_W  received data word
DVALID  output  1  DOUT holds an unconsumed word
DREADY  input  1  consumer accepts DOUT when DVALID&DREADY
PERR  output  1  parity error flag for the word in DOUT; valid while DVALID=1
OVF  output  1  one-cycle pulse: a completed frame was dropped
BUSY  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (RST=1 at a CK edge), regardless of state:
  - State goes to IDLE; bit counter and shift register go to 0.
  - DOUT=0, DVALID=0, PERR=0, OVF=0, BUSY=0.
  - A partially received frame is discarded with no OVF.
- States: IDLE, DATA, PARITY. All transitions occur only on cycles with SVALID=1. With SVALID=0, state, counter and shift register hold.
- IDLE:
  - SVALID=1 and SIN=1 is the start bit: go to DATA, counter=0.
  - SVALID=1 and SIN=0 is line idle: stay in IDLE.
- DATA:
  - Each strobe shifts SIN in at the MSB end and shifts the register right, so the first data bit ends in DOUT[0].
  - The counter increments.
  - On the strobe carrying data bit DATA_W-1, go to PARITY.
- PARITY:
  - The strobe carries the received parity bit P. Expected parity E = ^data when EVEN_PAR=1, else ~^data. Mismatch = (P != E).
  - Go to IDLE.
  - Completion edge, output full with no acceptance (DVALID=1 and DREADY=0): the frame is dropped, DOUT/PERR are unchanged, and OVF=1 for exactly the next cycle.
  - Completion edge, all other cases: DOUT<=data, PERR<=mismatch, DVALID<=1.
- Latency: DVALID rises in the cycle after the CK edge that samples the parity strobe.
- Output handshake:
  - DVALID&DREADY at an edge with no frame completing: DVALID<=0. DOUT and PERR hold their last value.
  - Acceptance and completion at the same edge: the new word loads, DVALID stays 1, no OVF.
  - DOUT/PERR never change while DVALID=1 and DREADY=0.
- Back-to-back frames: a start bit may arrive on the strobe immediately after the parity strobe. There are no dead cycles.
- OVF is 0 on every cycle other than the single pulse defined above.
- BUSY = (state != IDLE). It is registered: it rises the cycle after the start strobe and falls the cycle after the parity strobe.
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
1. Reset, then frame start,0xA5 LSB first, P=0, SVALID=1 every cycle, DREADY=1 -> DVALID=1 for one cycle with DOUT=0xA5, PERR=0, OVF=0. Latency is 1 cycle after the parity strobe.
2. Same frame with P=1 -> DOUT=0xA5, PERR=1. Then EVEN_PAR=0 build, 0xA5 with P=1 -> PERR=0.
3. SVALID toggling 1/0 every cycle during frame 0x3C -> identical result to continuous strobing. Idle strobes with SIN=0 before the start bit are ignored.
4. DREADY=0: frame 0x11 completes, then a second frame 0x22 completes -> DOUT stays 0x11, OVF pulses exactly one cycle. Raising DREADY leaves DVALID=0 afterwards.
5. DREADY asserted on the exact edge the second frame 0x22 completes (first 0x11 pending) -> DOUT=0x22, DVALID stays 1, OVF=0.
6. RST asserted after 4 data bits of a frame -> all outputs 0, BUSY=0. A following complete frame 0xFF, P=0 is received correctly with PERR=0.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: deserializes start/data/parity frames into a one-entry valid/ready output register.
module serial_frame_rx #(
  parameter int DATA_W   = 8,
  parameter bit EVEN_PAR = 1'b1
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              SIN,
  input  logic              SVALID,
  output logic [DATA_W-1:0] DOUT,
  output logic              DVALID,
  input  logic              DREADY,
  output logic              PERR,
  output logic              OVF,
  output logic              BUSY
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d, dout_q, dout_d;
  logic              dvalid_q, dvalid_d, perr_q, perr_d, ovf_q, ovf_d;
  logic              done, drop, load, exp_par;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    if (SVALID) begin
      case (state_q)
        IDLE: begin
          state_d = SIN ? DATA : IDLE;
          cnt_d   = SIN ? '0 : cnt_q;
        end
        DATA: begin
          sh_d    = {SIN, sh_q[DATA_W-1:1]};
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == LAST) ? PARITY : DATA;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // A completing frame is dropped only when the held word is neither consumed nor replaceable.
  assign done     = SVALID && (state_q == PARITY);
  assign drop     = done && dvalid_q && !DREADY;
  assign load     = done && !drop;
  assign exp_par  = EVEN_PAR ? ^sh_q : ~^sh_q;
  assign dout_d   = load ? sh_q : dout_q;
  assign perr_d   = load ? (SIN != exp_par) : perr_q;
  assign dvalid_d = load || (dvalid_q && !DREADY);
  assign ovf_d    = drop;
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      perr_q   <= perr_d;
      ovf_q    <= ovf_d;
    end
  end
  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign PERR   = perr_q;
  assign OVF    = ovf_q;
  assign BUSY   = (state_q != IDLE);
endmodule
